// File: rtl/spi_frame_arb_tx.sv
// spi_frame_arb_tx: two-requester round-robin SPI master for 48-bit frames.
// Each frame is sent as 6 bytes (byte 0 = data[7:0] first), each byte MSB
// first, in SPI mode 0. One CS window covers the whole frame by default.
// Build option: define SPI_CS_PER_BYTE_EN to raise CS for GAP_CYC cycles
// after each of bytes 0-4, which gives one CS window per byte.
module spi_frame_arb_tx #(
  parameter int CLK_DIV = 2,   // iclk cycles per SCK half-period (>=1)
  parameter int GAP_CYC = 4    // CS-high cycles after a frame (>=1)
) (
  input  logic        iclk,
  input  logic        rst,
  input  logic        req0,
  input  logic [47:0] data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [47:0] data1,
  output logic        ack1,
  output logic        busy,
  output logic        done,
  output logic        CS,
  output logic        SCK,
  output logic        MOSI
);

  // The one counter times SCK half-periods, LEAD/TRAIL and the CS-high gaps.
  localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

  // S_BGAP is the CS-high gap between bytes. It is reachable only when
  // per-byte chip select is built in.
  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_GAP, S_BGAP
  } state_t;

  state_t           r_state;
  logic             r_ptr;      // the side that wins when both request
  logic [47:0]      r_data;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [2:0]       r_byte;
  logic             r_cs;
  logic             r_sck;
  logic             r_mosi;
  logic             r_ack0;
  logic             r_ack1;
  logic             r_busy;
  logic             r_done;

  logic             w_grant1;
  logic [47:0]      w_sel_data;
  logic             w_div_end;
  logic             w_gap_end;
  logic             w_last_bit;
  logic             w_last_byte;
  logic [5:0]       w_nxt_idx;

  // A lone request always wins. When both sides request, the pointer picks the winner.
  assign w_grant1    = req1 & (~req0 | r_ptr);
  assign w_sel_data  = w_grant1 ? data1 : data0;
  assign w_div_end   = (r_cnt == DIV_LAST);
  assign w_gap_end   = (r_cnt == GAP_LAST);
  assign w_last_bit  = (r_bit == 3'd7);
  assign w_last_byte = (r_byte == 3'd5);
  // The bit shown at this falling edge is {byte, 7-bit}. 7-bit is ~bit in 3 bits.
  // After bit 7 the next bit is the MSB of the following byte.
  assign w_nxt_idx   = w_last_bit ? {r_byte + 3'd1, 3'b111}
                                  : {r_byte, ~(r_bit + 3'd1)};

  assign ack0 = r_ack0;
  assign ack1 = r_ack1;
  assign busy = r_busy;
  assign done = r_done;
  assign CS   = r_cs;
  assign SCK  = r_sck;
  assign MOSI = r_mosi;

  // Frame FSM. It does arbitration, CS/SCK/MOSI sequencing and the ack, busy and done pulses.
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_cs    <= 1'b1;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req0 | req1) begin
            r_data  <= w_sel_data;
            r_ack0  <= ~w_grant1;
            r_ack1  <= w_grant1;
            // The pointer moves only on contention. It then points at the loser.
            if (req0 & req1) r_ptr <= ~w_grant1;
            r_busy  <= 1'b1;
            r_cs    <= 1'b0;
            r_sck   <= 1'b0;
            r_mosi  <= w_sel_data[7];
            r_cnt   <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_state <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (w_div_end) begin
            r_cnt   <= '0;
            r_sck   <= 1'b1;
            r_state <= S_SHIFT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (!w_div_end) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
            if (r_sck) begin
              // Falling edge. This is the only place MOSI moves inside a window.
              r_sck <= 1'b0;
              if (!(w_last_bit && w_last_byte)) r_mosi <= r_data[w_nxt_idx];
            end else if (!w_last_bit) begin
              r_bit <= r_bit + 3'd1;
              r_sck <= 1'b1;
            end else begin
              r_bit <= '0;
`ifdef SPI_CS_PER_BYTE_EN
              r_state <= S_TRAIL;
`else
              if (w_last_byte) begin
                r_state <= S_TRAIL;
              end else begin
                r_byte <= r_byte + 3'd1;
                r_sck  <= 1'b1;
              end
`endif
            end
          end
        end
        S_TRAIL: begin
          if (w_div_end) begin
            r_cnt <= '0;
            r_cs  <= 1'b1;
`ifdef SPI_CS_PER_BYTE_EN
            if (w_last_byte) begin
              r_done  <= 1'b1;
              r_mosi  <= 1'b0;
              r_state <= S_GAP;
            end else begin
              r_byte  <= r_byte + 3'd1;
              r_state <= S_BGAP;
            end
`else
            r_done  <= 1'b1;
            r_mosi  <= 1'b0;
            r_state <= S_GAP;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (w_gap_end) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BGAP: begin
          // MOSI already holds the next byte's MSB from the last falling edge.
          if (w_gap_end) begin
            r_cnt   <= '0;
            r_cs    <= 1'b0;
            r_state <= S_LEAD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_arb_tx.sv
// tb_spi_frame_arb_tx: directed bench for spi_frame_arb_tx.
// Two instances run from one clock: [0] with CLK_DIV=2 and [1] with CLK_DIV=1.
// A pin-level monitor acts as the SPI slave. It rebuilds each frame from the SCK
// rising edges and checks the window lengths and the done/busy timing. It
// also compares every received frame against the queue of frames expected
// in grant order.
module tb_spi_frame_arb_tx;

  localparam int GAPC = 4;
`ifdef SPI_CS_PER_BYTE_EN
  localparam int WIN   = 18;  // LEAD + 16 half-periods + TRAIL, in half-periods
  localparam int WBITS = 8;
`else
  localparam int WIN   = 98;
  localparam int WBITS = 48;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 [2];
  logic        req1 [2];
  logic [47:0] data0 [2];
  logic [47:0] data1 [2];
  logic        ack0 [2];
  logic        ack1 [2];
  logic        busy [2];
  logic        done [2];
  logic        cs   [2];
  logic        sck  [2];
  logic        mosi [2];

  int checks = 0;
  int errors = 0;

  logic [47:0] q0[$];
  logic [47:0] q1[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_frame_arb_tx #(.CLK_DIV((g == 0) ? 2 : 1), .GAP_CYC(GAPC)) u_dut (
      .iclk(clk), .rst(rst),
      .req0(req0[g]), .data0(data0[g]), .ack0(ack0[g]),
      .req1(req1[g]), .data1(data1[g]), .ack1(ack1[g]),
      .busy(busy[g]), .done(done[g]),
      .CS(cs[g]), .SCK(sck[g]), .MOSI(mosi[g])
    );
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor state, one entry per instance.
  int          m_nb  [2];   // bits received in the current frame
  int          m_low [2];   // CS-low samples in the current window
  int          m_hi  [2];   // CS-high samples since the last CS rise
  int          m_wr  [2];   // SCK rises in the current window
  int          m_gl  [2];   // remaining post-frame busy samples
  bit          m_fr  [2];   // a frame is between ack and its end
  logic [47:0] m_rx  [2];
  logic        p_cs  [2];
  logic        p_sck [2];
  logic        p_mosi[2];

  // Pin-level compare process, sampling on the falling iclk edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        chk("rst_cs", cs[i], 1'b1);
        chk("rst_sck", sck[i], 1'b0);
        chk("rst_mosi", mosi[i], 1'b0);
        chk("rst_busy", busy[i], 1'b0);
        chk("rst_done", done[i], 1'b0);
        chk("rst_ack", {ack0[i], ack1[i]}, 2'b00);
        m_nb[i] = 0; m_low[i] = 0; m_hi[i] = 0; m_wr[i] = 0; m_gl[i] = 0;
        m_fr[i] = 1'b0; m_rx[i] = '0;
        p_cs[i] = 1'b1; p_sck[i] = 1'b0; p_mosi[i] = 1'b0;
      end else begin
        bit cs_rise, cs_fall, fend;
        int cdv;
        cdv = (i == 0) ? 2 : 1;
        if (ack0[i] || ack1[i]) m_fr[i] = 1'b1;
        chk("busy", busy[i], (m_fr[i] || m_gl[i] > 0));
        chk("ack_excl", ack0[i] & ack1[i], 1'b0);
        if (cs[i]) chk("sck_idle", sck[i], 1'b0);
        if (!cs[i] && !p_cs[i] && (mosi[i] !== p_mosi[i]) && !(p_sck[i] && !sck[i]))
          chk("mosi_only_at_fall", mosi[i], p_mosi[i]);
        if (!p_sck[i] && sck[i] && !cs[i]) begin
          if (m_nb[i] < 48) m_rx[i][(m_nb[i] / 8) * 8 + 7 - (m_nb[i] % 8)] = mosi[i];
          m_nb[i]++;
          m_wr[i]++;
        end
        if (!cs[i]) m_low[i]++; else m_hi[i]++;
        cs_rise = !p_cs[i] && cs[i];
        cs_fall = p_cs[i] && !cs[i];
        fend    = cs_rise && (m_nb[i] == 48);
        chk("done", done[i], fend);
        if (cs_rise) begin
          chk("cs_low_len", m_low[i], WIN * cdv);
          chk("window_rises", m_wr[i], WBITS);
          m_low[i] = 0; m_wr[i] = 0; m_hi[i] = 1;
        end
        if (cs_fall) begin
          if (m_nb[i] > 0 && m_nb[i] < 48) chk("byte_gap_len", m_hi[i], GAPC);
          m_hi[i] = 0;
        end
        if (fend) begin
          if (i == 0) begin
            chk("q0_has_exp", q0.size() > 0, 1'b1);
            if (q0.size() > 0) chk("frame0", m_rx[i], q0.pop_front());
          end else begin
            chk("q1_has_exp", q1.size() > 0, 1'b1);
            if (q1.size() > 0) chk("frame1", m_rx[i], q1.pop_front());
          end
          m_nb[i] = 0;
        end
        if (m_gl[i] > 0) m_gl[i]--;
        if (fend) begin
          m_fr[i] = 1'b0;
          m_gl[i] = GAPC - 1;
        end
        p_cs[i] = cs[i]; p_sck[i] = sck[i]; p_mosi[i] = mosi[i];
      end
    end
  end

  // Waits for ack<w> of instance i. c is the number of falling edges waited, or -1 on timeout.
  task automatic wait_ack(input int i, input int w, output int c);
    c = -1;
    for (int k = 1; k <= 400 && c < 0; k++) begin
      @(negedge clk);
      if ((w == 0) ? ack0[i] : ack1[i]) c = k;
    end
    if (c < 0) chk("ack_timeout", 1, 0);
  endtask

  // Counts from the current sample up to the done sample. It totals the CS-low
  // samples, the low samples with MOSI=1 and the low samples with SCK=1.
  task automatic wait_done(input int i, output int low, output int ones, output int sckh);
    bit ok;
    ok = 1'b0;
    low  = !cs[i] ? 1 : 0;
    ones = (!cs[i] && mosi[i]) ? 1 : 0;
    sckh = (!cs[i] && sck[i]) ? 1 : 0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      if (done[i]) ok = 1'b1;
      else if (!cs[i]) begin
        low++;
        if (mosi[i]) ones++;
        if (sck[i]) sckh++;
      end
    end
    if (!ok) chk("done_timeout", 1, 0);
  endtask

  task automatic wait_idle(input int i);
    bit ok;
    ok = !busy[i];
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (!busy[i]) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, low, ones, sckh, hi;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1'b0; req1[i] = 1'b0; data0[i] = '0; data1[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single frame from requester 0. The request is driven after one edge and
    // sampled at the next edge, so ack appears at the second falling edge.
    @(posedge clk); #1;
    req0[0] = 1'b1; data0[0] = 48'h0605_0403_0201; q0.push_back(48'h0605_0403_0201);
    wait_ack(0, 0, c);
    chk("A_ack_lat", c, 2);
    chk("A_busy", busy[0], 1'b1);
    chk("A_cs_low", cs[0], 1'b0);
    chk("A_mosi_first", mosi[0], 1'b0);
    req0[0] = 1'b0;
    wait_done(0, low, ones, sckh);
`ifdef SPI_CS_PER_BYTE_EN
    chk("A_low_total", low, 216);
`else
    chk("A_low_total", low, 196);
`endif
    chk("A_sck_high", sckh, 96);
    wait_idle(0);

    // Both requesters at once after reset. Requester 0 goes first, then 1 is
    // acked one cycle after the gap. A second contention then serves 1 before 0.
    @(posedge clk); #1;
    req0[0] = 1'b1; data0[0] = 48'hA1A2_A3A4_A5A6;
    req1[0] = 1'b1; data1[0] = 48'hB1B2_B3B4_B5B6;
    q0.push_back(48'hA1A2_A3A4_A5A6); q0.push_back(48'hB1B2_B3B4_B5B6);
    wait_ack(0, 0, c);
    chk("B_ack0_lat", c, 2);
    chk("B_ack1_quiet", ack1[0], 1'b0);
    req0[0] = 1'b0;
    wait_done(0, low, ones, sckh);
    wait_idle(0);
    wait_ack(0, 1, c);
    chk("B_ack1_after_gap", c, 1);
    req1[0] = 1'b0;
    wait_done(0, low, ones, sckh);
    wait_idle(0);
    @(posedge clk); #1;
    req0[0] = 1'b1; data0[0] = 48'hC0C0_C0C0_C0C0;
    req1[0] = 1'b1; data1[0] = 48'h1234_5678_9ABC;
    q0.push_back(48'h1234_5678_9ABC); q0.push_back(48'hC0C0_C0C0_C0C0);
    wait_ack(0, 1, c);
    chk("B2_ack1_lat", c, 2);
    chk("B2_ack0_quiet", ack0[0], 1'b0);
    req1[0] = 1'b0;
    wait_done(0, low, ones, sckh);
    wait_idle(0);
    wait_ack(0, 0, c);
    chk("B2_ack0_after_gap", c, 1);
    req0[0] = 1'b0;
    wait_done(0, low, ones, sckh);
    wait_idle(0);

    // Requester 1 is held continuously. Back-to-back frames are separated by
    // GAP_CYC + 1 CS-high samples.
    @(posedge clk); #1;
    req1[0] = 1'b1; data1[0] = 48'h5A5A_0FF0_C33C;
    q0.push_back(48'h5A5A_0FF0_C33C); q0.push_back(48'h5A5A_0FF0_C33C);
    wait_ack(0, 1, c);
    chk("C_ack_lat", c, 2);
    wait_done(0, low, ones, sckh);
    hi = 1; ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (cs[0]) hi++; else ok = 1'b1;
    end
    chk("C_cs_high_gap", hi, GAPC + 1);
    chk("C_ack_at_cs_fall", ack1[0], 1'b1);
    req1[0] = 1'b0;
    wait_done(0, low, ones, sckh);
    wait_idle(0);

    // Contention moves the pointer to 1. A reset in byte 3 then drops that
    // frame and returns the pointer to 0, so a fresh contention serves 0 first.
    @(posedge clk); #1;
    req0[0] = 1'b1; data0[0] = 48'hDEAD_BEEF_0000;
    req1[0] = 1'b1; data1[0] = 48'h0000_1111_2222;
    wait_ack(0, 0, c);
    chk("D_ack0_lat", c, 2);
    req0[0] = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (m_nb[0] >= 26) ok = 1'b1;
    end
    chk("D_reach_byte3", ok, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("D_rst_cs", cs[0], 1'b1);
    chk("D_rst_sck", sck[0], 1'b0);
    chk("D_rst_mosi", mosi[0], 1'b0);
    chk("D_rst_busy", busy[0], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    req0[0] = 1'b1; data0[0] = 48'h8001_4002_2004;
    q0.push_back(48'h8001_4002_2004); q0.push_back(48'h0000_1111_2222);
    wait_ack(0, 0, c);
    chk("D_ptr_reset_ack0", c, 2);
    chk("D_ptr_reset_ack1_quiet", ack1[0], 1'b0);
    req0[0] = 1'b0;
    wait_done(0, low, ones, sckh);
    wait_idle(0);
    wait_ack(0, 1, c);
    chk("D_ack1_after", c, 1);
    req1[0] = 1'b0;
    wait_done(0, low, ones, sckh);
    wait_idle(0);

    // CLK_DIV=1 instance with all ones, then all zeros.
    @(posedge clk); #1;
    req0[1] = 1'b1; data0[1] = 48'hFFFF_FFFF_FFFF; q1.push_back(48'hFFFF_FFFF_FFFF);
    wait_ack(1, 0, c);
    chk("E_ack_lat", c, 2);
    req0[1] = 1'b0;
    wait_done(1, low, ones, sckh);
`ifdef SPI_CS_PER_BYTE_EN
    chk("E1_low_total", low, 108);
    chk("E1_mosi_ones", ones, 108);
`else
    chk("E1_low_total", low, 98);
    chk("E1_mosi_ones", ones, 98);
`endif
    chk("E1_sck_high", sckh, 48);
    wait_idle(1);
    @(posedge clk); #1;
    req0[1] = 1'b1; data0[1] = 48'h0; q1.push_back(48'h0);
    wait_ack(1, 0, c);
    req0[1] = 1'b0;
    wait_done(1, low, ones, sckh);
    chk("E0_mosi_ones", ones, 0);
    chk("E0_sck_high", sckh, 48);
    wait_idle(1);

    repeat (5) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
